// File: rtl/elm_pkg.sv
// elm_pkg: constants shared by the one-hot target decoder, the argmax
// encoder and the ELM training datapath.
//   N_CLASSES  number of classes / beats per frame
//   DATA_W     signed score word width (Q8.8)
//   FRAC_W     fractional bits of the score word
//   CNT_W      width of label and 1-based beat counter
//   ONE / OFF  target levels for the hit / non-hit classes
// Optional build macro: BIPOLAR_TARGET_EN selects OFF = -ONE (bipolar
// targets); without it OFF = 0 (unipolar one-hot).
package elm_pkg;

  localparam int N_CLASSES = 10;
  localparam int DATA_W    = 16;
  localparam int FRAC_W    = 8;
  localparam int CNT_W     = 4;

  localparam logic signed [DATA_W-1:0] ONE = DATA_W'(1 << FRAC_W);
`ifdef BIPOLAR_TARGET_EN
  localparam logic signed [DATA_W-1:0] OFF = -ONE;
`else
  localparam logic signed [DATA_W-1:0] OFF = '0;
`endif

  // Beat counter value of the final beat of a frame.
  localparam logic [CNT_W-1:0] N_CNT = CNT_W'(N_CLASSES);

  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE   = 1'b0;
  localparam state_t ST_STREAM = 1'b1;

endpackage

// File: rtl/onehot_decoder.sv
// onehot_decoder: accepts a class label and streams its one-hot target
// vector, one signed Q8.8 score per beat, with a 1-based beat count.
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   label_valid  label offered            label_ready  label can be taken
//   label        class index              label_err    out-of-range label dropped (1-cycle pulse)
//   out_valid    score beat valid         out_ready    downstream accepts beat
//   out_data     score of class count-1   count        beat index 1..N_CLASSES, 0 when idle
//   out_last     final beat of the frame
// Build option: BIPOLAR_TARGET_EN (see elm_pkg) sets the non-hit score to -1.0.
//
// state     | meaning
// ST_IDLE   | waiting for a label; label_ready high
// ST_STREAM | emitting beats 1..N_CLASSES of the latched label
module onehot_decoder
  import elm_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     label_valid,
  output logic                     label_ready,
  input  logic [CNT_W-1:0]         label,
  output logic                     label_err,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]         count,
  output logic                     out_last
);

  state_t                     state_q, state_d;
  logic [CNT_W-1:0]           label_q, label_d;
  logic [CNT_W-1:0]           count_q, count_d;
  logic signed [DATA_W-1:0]   out_data_q, out_data_d;
  logic                       out_last_q, out_last_d;
  logic                       label_err_q, label_err_d;
  logic                       label_ready_q, label_ready_d;
  logic [CNT_W-1:0]           count_inc;

  assign count_inc = count_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    label_d     = label_q;
    count_d     = count_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    label_err_d = 1'b0;

    if (state_q == ST_IDLE) begin
      if (label_ready_q && label_valid) begin
        if (label < N_CNT) begin
          state_d    = ST_STREAM;
          label_d    = label;
          count_d    = CNT_W'(1);
          out_data_d = (label == '0) ? ONE : OFF;
          out_last_d = (N_CNT == CNT_W'(1));
        end else begin
          label_err_d = 1'b1;
        end
      end
    end else begin
      if (out_ready) begin
        if (count_q == N_CNT) begin
          state_d    = ST_IDLE;
          count_d    = '0;
          out_data_d = '0;
          out_last_d = 1'b0;
        end else begin
          // Next beat is count_q+1, which carries class index count_q.
          count_d    = count_inc;
          out_data_d = (count_q == label_q) ? ONE : OFF;
          out_last_d = (count_inc == N_CNT);
        end
      end
    end

    label_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      label_q       <= '0;
      count_q       <= '0;
      out_data_q    <= '0;
      out_last_q    <= 1'b0;
      label_err_q   <= 1'b0;
      label_ready_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      label_q       <= label_d;
      count_q       <= count_d;
      out_data_q    <= out_data_d;
      out_last_q    <= out_last_d;
      label_err_q   <= label_err_d;
      label_ready_q <= label_ready_d;
    end
  end

  assign label_ready = label_ready_q;
  assign label_err   = label_err_q;
  assign out_valid   = (state_q == ST_STREAM);
  assign out_data    = out_data_q;
  assign count       = count_q;
  assign out_last    = out_last_q;

endmodule

// File: tb/tb_onehot_decoder.sv
module tb_onehot_decoder;

  localparam int NC      = 10;
  localparam int EXP_ONE = 256;
`ifdef BIPOLAR_TARGET_EN
  localparam int EXP_OFF = -256;
`else
  localparam int EXP_OFF = 0;
`endif

  localparam int M_ALWAYS = 0;
  localparam int M_TOGGLE = 1;
  localparam int M_RANDOM = 2;

  logic               clk;
  logic               rst_n;
  logic               label_valid;
  logic               label_ready;
  logic [3:0]         label;
  logic               label_err;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_data;
  logic [3:0]         count;
  logic               out_last;

  int vectors;
  int miscompares;

  typedef struct {
    int cnt;
    int data;
    int last;
  } beat_t;

  typedef struct {
    int lab;
    int mode;
  } vec_t;

  onehot_decoder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .label_valid (label_valid),
    .label_ready (label_ready),
    .label       (label),
    .label_err   (label_err),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .count       (count),
    .out_last    (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, " label_ready"}, int'(label_ready), 1);
    check({tag, " out_valid"},   int'(out_valid), 0);
    check({tag, " count"},       int'(count), 0);
  endtask

  // Reference frame: beat k carries ONE when k-1 is the label, else OFF.
  // Called at #1 after the accept edge; drains the frame under the given
  // out_ready policy and returns at #1 after the out_last transfer edge.
  task automatic drain(input int lab, input int mode);
    beat_t q[$];
    beat_t b;
    int    cyc;
    bit    rdy;
    for (int k = 1; k <= NC; k++) begin
      b.cnt  = k;
      b.data = (k - 1 == lab) ? EXP_ONE : EXP_OFF;
      b.last = (k == NC) ? 1 : 0;
      q.push_back(b);
    end
    cyc = 0;
    while (q.size() > 0) begin
      if (cyc > 20 * NC) begin
        check("frame timeout", q.size(), 0);
        return;
      end
      b = q[0];
      check("out_valid", int'(out_valid), 1);
      check("label_ready in stream", int'(label_ready), 0);
      check("count", int'(count), b.cnt);
      check("out_data", int'($signed(out_data)), b.data);
      check("out_last", int'(out_last), b.last);
      case (mode)
        M_ALWAYS: rdy = 1'b1;
        M_TOGGLE: rdy = (cyc % 3) == 0;
        default:  rdy = $urandom_range(1, 0) == 1;
      endcase
      out_ready = rdy;
      if (rdy) void'(q.pop_front());
      step();
      cyc++;
    end
    out_ready = 1'b0;
  endtask

  // Offer a label from IDLE; in-range labels run a full frame, others
  // must produce a single label_err pulse and no beats.
  task automatic run_label(input int lab, input int mode);
    check_idle("pre-offer");
    label_valid = 1'b1;
    label       = 4'(lab);
    step();
    label_valid = 1'b0;
    if (lab < NC) begin
      check("label_err on accept", int'(label_err), 0);
      drain(lab, mode);
      check_idle("post-frame");
    end else begin
      check("label_err pulse", int'(label_err), 1);
      check("no beat on bad label", int'(out_valid), 0);
      step();
      check("label_err one cycle", int'(label_err), 0);
      check_idle("after bad label");
    end
  endtask

  vec_t vecs[$];

  initial begin
    int  cyc;
    int  lab;
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    label_valid = 1'b0;
    label       = '0;
    out_ready   = 1'b0;

    step();
    step();
    check("rst out_valid",   int'(out_valid), 0);
    check("rst out_data",    int'($signed(out_data)), 0);
    check("rst count",       int'(count), 0);
    check("rst out_last",    int'(out_last), 0);
    check("rst label_err",   int'(label_err), 0);
    check("rst label_ready", int'(label_ready), 0);
    rst_n = 1'b1;
    step();
    check("label_ready after reset", int'(label_ready), 1);

    vecs.push_back('{3,  M_ALWAYS});
    vecs.push_back('{0,  M_ALWAYS});
    vecs.push_back('{9,  M_TOGGLE});
    vecs.push_back('{12, M_ALWAYS});
    vecs.push_back('{5,  M_ALWAYS});
    vecs.push_back('{15, M_RANDOM});
    vecs.push_back('{10, M_ALWAYS});
    vecs.push_back('{7,  M_RANDOM});
    foreach (vecs[i]) run_label(vecs[i].lab, vecs[i].mode);

    // Reset in the middle of a label-7 frame, then a clean label-2 frame.
    label_valid = 1'b1;
    label       = 4'd7;
    step();
    label_valid = 1'b0;
    out_ready   = 1'b1;
    cyc = 0;
    while (count != 4'd6 && cyc < 4 * NC) begin
      step();
      cyc++;
    end
    check("reached count 6", int'(count), 6);
    rst_n = 1'b0;
    step();
    check("mid-reset out_valid", int'(out_valid), 0);
    check("mid-reset count", int'(count), 0);
    check("mid-reset out_data", int'($signed(out_data)), 0);
    check("mid-reset out_last", int'(out_last), 0);
    rst_n     = 1'b1;
    out_ready = 1'b0;
    step();
    check("mid-reset no resume", int'(out_valid), 0);
    run_label(2, M_ALWAYS);

    // Back-to-back: label_valid held high, label 1 then 8.
    check_idle("b2b start");
    label_valid = 1'b1;
    label       = 4'd1;
    step();
    label = 4'd8;
    drain(1, M_ALWAYS);
    check("b2b label_ready gap", int'(label_ready), 1);
    check("b2b no interleave", int'(out_valid), 0);
    step();
    label_valid = 1'b0;
    drain(8, M_ALWAYS);
    check_idle("b2b end");

    // Randomized labels (some out of range) and random back-pressure.
    for (int n = 0; n < 25; n++) begin
      lab = int'($urandom_range(15, 0));
      run_label(lab, M_RANDOM);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/onehot_decoder.md
Name: onehot_decoder

Overview:
- Inverse of the argmax/one-hot encoding stage: takes a class label (handwritten digit 0..9) and streams the matching one-hot target vector, one class score per beat.
- Score words use the same signed 16-bit fixed-point format and 1-based `count` indexing that the output-layer datapath consumes.
- Feeds ELM output-weight training (target matrix T) and lets the bench drive the argmax encoder with known score streams.

Parameters:
- N_CLASSES, 10, number of classes / beats per frame.
- DATA_W, 16, width of the signed score word.
- FRAC_W, 8, fractional bits; ONE = 2^FRAC_W (Q8.8: +1.0 = 16'sd256).
- CNT_W, 4, width of `label` and `count`; must satisfy 2^CNT_W > N_CLASSES.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active-low.
- label_valid  input  1  label offered.
- label_ready  output  1  block can accept a label.
- label  input  CNT_W  class index 0..N_CLASSES-1.
- label_err  output  1  one-cycle pulse: out-of-range label was dropped.
- out_valid  output  1  score beat valid.
- out_ready  input  1  downstream accepts beat.
- out_data  output  DATA_W  signed score for class count-1.
- count  output  CNT_W  1-based beat index (1..N_CLASSES), 0 when idle.
- out_last  output  1  high on beat count==N_CLASSES.

Behaviour:
- Reset: while rst_n is low at a clock edge, the block enters IDLE.
  - out_valid=0, out_data=0, count=0, out_last=0, label_err=0, label_ready=0.
  - label_ready goes to 1 on the first cycle after rst_n is high.
  - Reset mid-stream aborts the frame immediately; the partial frame is never resumed.
- FSM states: IDLE, STREAM.
- IDLE:
  - label_ready=1, out_valid=0, count=0.
  - On label_valid && label < N_CLASSES: latch label, go to STREAM.
  - On label_valid && label >= N_CLASSES: pulse label_err for exactly one cycle (the cycle after acceptance), stay in IDLE, emit nothing.
- STREAM:
  - label_ready=0. Labels offered in this state are not accepted and must be held by the sender.
  - out_valid=1. Beat k (count=k, k=1..N_CLASSES): out_data = ONE if k-1 == latched label, else OFF.
  - out_last = (count==N_CLASSES).
- Latency: label accepted at edge t → first beat (count=1) valid after edge t, i.e. registered, one cycle.
- Handshake:
  - A beat transfers when out_valid && out_ready.
  - While out_ready=0, out_data, count and out_last hold stable.
  - count advances by exactly 1 per transfer. There are no gaps when out_ready stays high, so a frame takes N_CLASSES cycles.
- End of frame: the transfer with out_last=1 returns the FSM to IDLE. label_ready=1 the following cycle.
  - Minimum label-to-label spacing is N_CLASSES+1 cycles.
- All outputs are registered; no combinational path from out_ready or label_valid to any output except none (label_ready is state-decoded).
- Width rules:
  - label is compared unsigned.
  - ONE and OFF are constants of width DATA_W; no arithmetic overflow is possible.
  - count never wraps: it is 0 in IDLE and 1..N_CLASSES in STREAM.

Optional Feature:
- Macro BIPOLAR_TARGET_EN.
- Defined: OFF = -ONE (16'shFF00), giving ELM bipolar targets.
- Undefined: OFF = 0, giving unipolar one-hot.
- Handshake and timing are identical in both builds.

Decomposition:
- Shared package `elm_pkg`:
  - N_CLASSES, DATA_W, FRAC_W, CNT_W.
  - ONE/OFF constants.
  - FSM state typedef (IDLE, STREAM).
  - These are also used by the encoder and the training datapath.
- No sub-module; a single FSM + counter + compare is natural.

Test Plan:
- Default build, label=3, out_ready=1 → 10 consecutive beats: count=1..10, out_data=256 only at count=4, all other beats 0; out_last only at count=10; label_ready=1 one cycle later.
- BIPOLAR_TARGET_EN build, label=0 → count=1 has out_data=256; count=2..10 have out_data=-256 (16'hFF00).
- label=9 with out_ready toggling 1,0,0,1,... → outputs stable while stalled; exactly 10 transfers; 256 at count=10 together with out_last.
- label=12 → label_err high for one cycle, no out_valid; next label=5 is accepted normally.
- rst_n driven low at count=6 of label=7 → next cycle out_valid=0, count=0; new label=2 then produces a clean full frame.
- Two labels back-to-back (1, then 8, label_valid held high) → second label accepted only in the cycle after the first frame's out_last transfer; frames do not interleave.
